// File: rtl/clk_div_bank_pkg.sv
// Shared types for the clock divider bank: per-channel config record, FSM states
// and the field clamp applied when a config write is accepted.
package clk_div_bank_pkg;

  localparam int CFG_W = 16;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
    logic             enable;
  } ch_cfg_t;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam ch_cfg_t CH_CFG_DEFAULT = '{
    div:    CFG_W'(2),
    high:   CFG_W'(1),
    phase:  CFG_W'(0),
    enable: 1'b1
  };

  // A divide below 2 parks the channel; high and phase are pulled inside one period.
  function automatic ch_cfg_t clamp_cfg(input logic [CFG_W-1:0] div,
                                        input logic [CFG_W-1:0] high,
                                        input logic [CFG_W-1:0] phase);
    ch_cfg_t c;
    c.div    = div;
    c.enable = (div >= CFG_W'(2));
    c.high   = (high >= div) ? div - CFG_W'(1) : high;
    c.phase  = (phase >= div) ? '0 : phase;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, registered outclk/tick decode and, when
// CLK_DIV_BANK_HITLESS_EN is defined, a shadow config applied at the period wrap.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic    refclk,
  input  logic    rst_n,
  input  logic    wr,
  input  ch_cfg_t cfg_in,
  input  logic    start,
  input  logic    active_next,
  output logic    outclk,
  output logic    tick
);

  ch_cfg_t          cfg;
  ch_cfg_t          cfg_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CFG_W-1:0] cnt_ext;
  logic [CFG_W-1:0] cnt_next_ext;
  logic             wrap;
  logic             cfg_unused;

`ifdef CLK_DIV_BANK_HITLESS_EN
  ch_cfg_t shadow;
  ch_cfg_t shadow_next;
  logic    pending;
  logic    pending_next;
`endif

  assign cnt_ext      = CFG_W'(cnt);
  assign cnt_next_ext = CFG_W'(cnt_next);
  assign wrap         = (cnt_ext == cfg.div - CFG_W'(1));
  assign cfg_unused   = ^cfg.phase;

  // Outputs decode the next count so the flops present the current count's value.
  always_comb begin
    cfg_next = cfg;
    cnt_next = cnt;
`ifdef CLK_DIV_BANK_HITLESS_EN
    shadow_next  = wr ? cfg_in : shadow;
    pending_next = wr | pending;
`else
    if (wr) begin
      cfg_next = cfg_in;
    end
`endif
    if (start) begin
      cnt_next = cfg.phase[CNT_W-1:0];
    end else if (active_next) begin
      cnt_next = wrap ? '0 : cnt + CNT_W'(1);
`ifdef CLK_DIV_BANK_HITLESS_EN
      if (pending_next && (wrap || !cfg.enable)) begin
        cfg_next     = shadow_next;
        pending_next = 1'b0;
        cnt_next     = '0;
      end
`endif
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg    <= CH_CFG_DEFAULT;
      cnt    <= '0;
      outclk <= 1'b0;
      tick   <= 1'b0;
    end else begin
      cfg    <= cfg_next;
      cnt    <= cnt_next;
      outclk <= active_next && cfg_next.enable && (cnt_next_ext < cfg_next.high);
      tick   <= active_next && cfg_next.enable && (cnt_next == '0);
    end
  end

`ifdef CLK_DIV_BANK_HITLESS_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= CH_CFG_DEFAULT;
      pending <= 1'b0;
    end else begin
      shadow  <= shadow_next;
      pending <= pending_next;
    end
  end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel divided-clock generator with settle/lock sequencing; optional
// hitless reprogramming is enabled by defining CLK_DIV_BANK_HITLESS_EN.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter  int NUM_CLK     = 4,
  parameter  int CNT_W       = 8,
  parameter  int LOCK_CYCLES = 64,
  localparam int CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_phase,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] tick,
  output logic               locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t           state;
  state_t           state_next;
  logic [SET_W-1:0] settle_cnt;
  logic             accept;
  logic             ch_hit;
  logic             settle_done;
  logic             start;
  logic             active_next;
  ch_cfg_t          cfg_clamped;

  assign accept      = cfg_valid && cfg_ready;
  assign ch_hit      = accept && (int'(cfg_ch) < NUM_CLK);
  assign settle_done = (settle_cnt == SET_W'(LOCK_CYCLES - 1));
  assign start       = (state == SETTLE) && (state_next == RUN);
  assign active_next = (state_next == RUN);
  assign cfg_clamped = clamp_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high), CFG_W'(cfg_phase));

  // Without hitless support any accepted write restarts every channel through SETTLE.
  always_comb begin
    state_next = state;
    case (state)
      SETTLE: begin
        if (settle_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
`ifndef CLK_DIV_BANK_HITLESS_EN
        if (ch_hit) begin
          state_next = SETTLE;
        end
`endif
      end
      default: state_next = SETTLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= ((state == SETTLE) && (state_next == SETTLE)) ?
                    settle_cnt + SET_W'(1) : '0;
      locked     <= active_next;
      cfg_ready  <= active_next;
    end
  end

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .wr         (ch_hit && (cfg_ch == CH_W'(i))),
      .cfg_in     (cfg_clamped),
      .start      (start),
      .active_next(active_next),
      .outclk     (outclk[i]),
      .tick       (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed and random config writes checked every cycle
// against an arithmetic model (period position = phase + cycles since lock, mod div).
`timescale 1ns/1ps
module tb_clk_div_bank;

  localparam int NUM_CLK     = 4;
  localparam int CNT_W       = 8;
  localparam int LOCK_CYCLES = 64;
  localparam int CH_W        = 2;
  localparam int NEVER       = 32'h3fff_ffff;

  logic               refclk    = 1'b0;
  logic               rst_n     = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch    = '0;
  logic [CNT_W-1:0]   cfg_div   = '0;
  logic [CNT_W-1:0]   cfg_high  = '0;
  logic [CNT_W-1:0]   cfg_phase = '0;
  logic [NUM_CLK-1:0] outclk;
  logic [NUM_CLK-1:0] tick;
  logic               locked;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int run_e0   = NEVER;
  bit accept_seen = 1'b0;

  int m_div   [NUM_CLK];
  int m_high  [NUM_CLK];
  int m_phase [NUM_CLK];
  bit m_en    [NUM_CLK];

  clk_div_bank #(
    .NUM_CLK    (NUM_CLK),
    .CNT_W      (CNT_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .tick     (tick),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) edge_cnt++;

  task automatic modelDefaults();
    for (int i = 0; i < NUM_CLK; i++) begin
      m_div[i]   = 2;
      m_high[i]  = 1;
      m_phase[i] = 0;
      m_en[i]    = 1'b1;
    end
  endtask

  task automatic modelWrite(input int ch, input int div, input int high, input int phase);
    m_en[ch]    = (div >= 2);
    m_div[ch]   = div;
    m_high[ch]  = (high >= div) ? div - 1 : high;
    m_phase[ch] = (phase >= div) ? 0 : phase;
  endtask

  function automatic void expectAt(input int e, output logic lk,
                                   output logic [NUM_CLK-1:0] oc,
                                   output logic [NUM_CLK-1:0] tk);
    int c;
    lk = (e >= run_e0);
    oc = '0;
    tk = '0;
    if (lk) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        if (m_en[i]) begin
          c     = (m_phase[i] + e - run_e0) % m_div[i];
          oc[i] = (c < m_high[i]);
          tk[i] = (c == 0);
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag);
    logic               elk;
    logic [NUM_CLK-1:0] eoc;
    logic [NUM_CLK-1:0] etk;
    expectAt(edge_cnt, elk, eoc, etk);
    checks++;
    assert (locked === elk) else begin
      failures++;
      $error("[TB] FAIL %s locked: got %b expected %b (edge %0d)", tag, locked, elk, edge_cnt);
    end
    checks++;
    assert (cfg_ready === elk) else begin
      failures++;
      $error("[TB] FAIL %s cfg_ready: got %b expected %b (edge %0d)", tag, cfg_ready, elk, edge_cnt);
    end
    checks++;
    assert (outclk === eoc) else begin
      failures++;
      $error("[TB] FAIL %s outclk: got %b expected %b (edge %0d)", tag, outclk, eoc, edge_cnt);
    end
    checks++;
    assert (tick === etk) else begin
      failures++;
      $error("[TB] FAIL %s tick: got %b expected %b (edge %0d)", tag, tick, etk, edge_cnt);
    end
  endtask

  // A write is taken at the next edge when the model says the bank is ready now.
  task automatic handleValid();
    logic               elk;
    logic [NUM_CLK-1:0] eoc;
    logic [NUM_CLK-1:0] etk;
    if (accept_seen) begin
      cfg_valid   = 1'b0;
      accept_seen = 1'b0;
    end else if (cfg_valid && rst_n) begin
      expectAt(edge_cnt, elk, eoc, etk);
      if (elk) begin
        modelWrite(int'(cfg_ch), int'(cfg_div), int'(cfg_high), int'(cfg_phase));
        run_e0      = edge_cnt + 1 + LOCK_CYCLES;
        accept_seen = 1'b1;
      end
    end
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge refclk);
      checkOutput(tag);
      handleValid();
    end
  endtask

  task automatic applyStimulus(input int ch, input int div, input int high,
                               input int phase, input string tag);
    int guard;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(div);
    cfg_high  = CNT_W'(high);
    cfg_phase = CNT_W'(phase);
    cfg_valid = 1'b1;
    handleValid();
    guard = 0;
    while (cfg_valid && guard < 4 * LOCK_CYCLES) begin
      runCycles(1, tag);
      guard++;
    end
    cfg_valid = 1'b0;
    runCycles(LOCK_CYCLES + 30, tag);
  endtask

  initial begin
    modelDefaults();
    run_e0 = NEVER;
    runCycles(4, "in_reset");

    rst_n  = 1'b1;
    run_e0 = edge_cnt + LOCK_CYCLES;
    runCycles(LOCK_CYCLES + 16, "defaults");

    applyStimulus(1, 5, 2, 3, "ch1_div5");
    applyStimulus(2, 4, 9, 7, "clamp_high_phase");
    applyStimulus(3, 1, 0, 0, "div1_disabled");
    applyStimulus(0, 7, 0, 2, "high_zero");

    for (int r = 0; r < 5; r++) begin
      applyStimulus($urandom_range(0, NUM_CLK - 1), $urandom_range(0, 12),
                    $urandom_range(0, 14), $urandom_range(0, 14), "random_cfg");
    end

    // One-cycle reset in the middle of RUN clears everything without waiting for an edge.
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    accept_seen = 1'b0;
    modelDefaults();
    run_e0      = NEVER;
    #1;
    checkOutput("async_reset");
    @(negedge refclk);
    checkOutput("async_reset_hold");
    rst_n  = 1'b1;
    run_e0 = edge_cnt + LOCK_CYCLES;

    applyStimulus(0, 3, 1, 2, "valid_in_settle");
    applyStimulus(2, $urandom_range(2, 9), $urandom_range(0, 9),
                  $urandom_range(0, 9), "post_reset_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable/divided-clock generator with lock sequencing, the RTL successor to our fixed single-output 125→625 MHz PLL wrapper. From one reference clock it produces NUM_CLK divided outputs, each with its own runtime-programmable divide ratio, high time (duty) and phase offset. After every reset or reconfiguration, a settle interval runs before `locked` asserts with all channels phase-aligned. It sits beside the PLL in the clocking subsystem and feeds per-port MAC/PCS logic with aligned enables.

## Interface
- NUM_CLK, 4, number of output channels (1..8)
- CNT_W, 8, width of divide/high/phase fields
- LOCK_CYCLES, 64, settle interval in refclk cycles (≥1)
- refclk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&&ready
- cfg_ch  in  $clog2(NUM_CLK) (min 1)  target channel; values ≥NUM_CLK accepted and ignored
- cfg_div  in  CNT_W  period in refclk cycles
- cfg_high  in  CNT_W  cycles high per period
- cfg_phase  in  CNT_W  counter start value at lock
- outclk  out  NUM_CLK  divided clocks, registered
- tick  out  NUM_CLK  one-cycle pulse at each channel's counter==0, registered
- locked  out  1  all channels running and aligned

## Operation
- States: SETTLE, RUN. Reset enters SETTLE with settle counter 0.
- SETTLE: cfg_ready=0 except as below; outclk=0, tick=0, locked=0; settle counter increments; at LOCK_CYCLES-1 → RUN, every cnt_i loaded with phase_i.
- RUN: locked=1, cfg_ready=1; cnt_i increments, wraps at div_i-1 → 0; outclk_i=(cnt_i<high_i); tick_i=(cnt_i==0).
- Config accept (valid&&ready) in RUN: register the channel's fields, → SETTLE with settle counter cleared (all channels restart aligned).
- Field clamping at accept: div<2 → channel disabled (outclk_i=0, tick_i=0 permanently); high≥div → high=div-1; phase≥div → phase=0. high=0 → outclk_i stays 0, ticks still occur.
- Reset values: outclk=0, tick=0, locked=0, cfg_ready=0; every channel div=2, high=1, phase=0.
- Mid-operation reset: immediate async clear to reset values; no partial config retained.

## Timing
- Accept in cycle T → cycle T+1: locked=0, outclk=0, cfg_ready=0.
- locked=1 first in cycle T+1+LOCK_CYCLES; in that cycle cnt_i=phase_i, outputs decode it (outclk_i=(phase_i<high_i), tick_i=(phase_i==0)).
- After reset release: first RUN cycle = release + LOCK_CYCLES.
- Channels with equal div and phase are cycle-identical; period of outclk_i and tick_i is exactly div_i cycles.

## Configuration
- CLK_DIV_BANK_HITLESS_EN defined: writes in RUN do not leave RUN; locked stays 1, cfg_ready stays 1. Fields go to a per-channel shadow and are applied at that channel's next wrap (cycle where cnt_i==div_i-1; next cycle uses new div/high with cnt=0, phase ignored). Disabled channel applies at the next cycle. A second write to the same channel before apply overwrites the shadow.
- Undefined: every accept in RUN restarts through SETTLE as above. SETTLE behaviour is identical in both builds.

## Structure
- Package clk_div_bank_pkg: ch_cfg_t struct (div, high, phase, enable), state enum {SETTLE, RUN}, default-config constant, clamp function.
- Sub-module clk_div_chan: one channel counter, output decode, and (under macro) shadow register; instantiated NUM_CLK times by generate. Top holds FSM, settle counter, and config decode.

## Test plan
- Reset, defaults, LOCK_CYCLES=64 → locked rises 64 cycles after release; all outclk toggle 1,0 with period 2, ticks aligned.
- Ch1 div=5 high=2 phase=3 → after relock, ch1 sequence 0,0,1,1,0 repeating with tick at 3rd cycle; other channels unchanged and aligned.
- Clamp: div=4 high=9 phase=7 → outclk high 3 of 4 cycles, phase 0; div=1 → channel constant 0, no ticks.
- Assert rst_n low mid-RUN for one cycle → outputs, locked cleared same cycle; defaults restored; relock after 64 cycles.
- cfg_valid held during SETTLE → no accept (cfg_ready=0); accepted on first RUN cycle, locked drops the next cycle.
- HITLESS build: ch0 div 4→6 at random point → locked never drops, old period completes, next period is 6 cycles.
